// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 3-bit VGA frame buffer.
// Generates 640x480@60 raster timing from the system clock. It fetches a 320x240
// image through the buffer read port, which has a 1-clock read latency. Each stored
// pixel is shown twice horizontally and on two lines vertically.
// Ports:
//   clock, reset_n      system clock (posedge), asynchronous active-low reset
//   enable              1 = scan, 0 = hold at frame origin with outputs blanked
//   rd_en, rd_addr      frame buffer read request, issued on each active pixel tick
//   rd_data             frame buffer word, valid 1 clock after rd_en
//   vga_r/g/b           colour bits (rd_data[2]/[1]/[0] in active video, else 0)
//   hsync_n, vsync_n    active-low sync pulses
//   blank_n             1 during active video
//   frame_start         1-clock pulse with the first active pixel of each frame
module vga_scanout #(
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned FB_W     = 320,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_data,
  output logic              vga_r,
  output logic              vga_g,
  output logic              vga_b,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = $clog2(PIX_DIV);
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);

  // Raster counters and the base address of the current image row
  logic [DIV_W-1:0]  div_q, div_d;
  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [ADDR_W-1:0] row_q, row_d;

  // Read request
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  // Position attributes captured on the tick, applied one clock later with the RAM data
  logic              pv_q, pv_d;
  logic              p_blank_q, p_blank_d;
  logic              p_hs_n_q, p_hs_n_d;
  logic              p_vs_n_q, p_vs_n_d;
  logic              p_first_q, p_first_d;

  // Output stage
  logic [2:0]        rgb_q, rgb_d;
  logic              hs_n_q, hs_n_d;
  logic              vs_n_q, vs_n_d;
  logic              blank_q, blank_d;
  logic              fs_q, fs_d;

  logic              tick;
  logic              fetch;

  // Next-state logic for counters, fetch and output stage
  always_comb begin
    tick      = (div_q == DIV_W'(PIX_DIV - 1));
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    h_d       = h_q;
    v_d       = v_q;
    row_d     = row_q;
    pv_d      = tick;
    p_blank_d = p_blank_q;
    p_hs_n_d  = p_hs_n_q;
    p_vs_n_d  = p_vs_n_q;
    p_first_d = p_first_q;
    rgb_d     = rgb_q;
    hs_n_d    = hs_n_q;
    vs_n_d    = vs_n_q;
    blank_d   = blank_q;
    fs_d      = 1'b0;

    if (tick) begin
      if (h_q == H_W'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == V_W'(V_TOTAL - 1)) begin
          v_d   = '0;
          row_d = '0;
        end else begin
          v_d = v_q + V_W'(1);
          // Each image row covers two display lines: step the row base after odd lines
          if (v_q[0] && (v_q < V_W'(V_ACTIVE))) begin
            row_d = row_q + ADDR_W'(FB_W);
          end
        end
      end else begin
        h_d = h_q + H_W'(1);
      end
      p_blank_d = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
      p_hs_n_d  = !((h_q >= H_W'(HS_START)) && (h_q < H_W'(HS_END)));
      p_vs_n_d  = !((v_q >= V_W'(VS_START)) && (v_q < V_W'(VS_END)));
      p_first_d = (h_q == '0) && (v_q == '0);
    end

    // Registered read request: asserted for exactly the tick cycle of an active pixel
    fetch     = (div_d == DIV_W'(PIX_DIV - 1)) &&
                (h_d < H_W'(H_ACTIVE)) && (v_d < V_W'(V_ACTIVE));
    rd_en_d   = fetch;
    rd_addr_d = fetch ? row_d + ADDR_W'(h_d >> 1) : rd_addr_q;

    // Output stage loads one clock after the tick, when rd_data is valid
    if (pv_q) begin
      rgb_d   = p_blank_q ? rd_data : 3'b000;
      hs_n_d  = p_hs_n_q;
      vs_n_d  = p_vs_n_q;
      blank_d = p_blank_q;
      fs_d    = p_first_q;
    end

    // Disabled: park at the frame origin with outputs at their idle values
    if (!enable) begin
      div_d     = '0;
      h_d       = '0;
      v_d       = '0;
      row_d     = '0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      pv_d      = 1'b0;
      p_blank_d = 1'b0;
      p_hs_n_d  = 1'b1;
      p_vs_n_d  = 1'b1;
      p_first_d = 1'b0;
      rgb_d     = 3'b000;
      hs_n_d    = 1'b1;
      vs_n_d    = 1'b1;
      blank_d   = 1'b0;
      fs_d      = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      row_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pv_q      <= 1'b0;
      p_blank_q <= 1'b0;
      p_hs_n_q  <= 1'b1;
      p_vs_n_q  <= 1'b1;
      p_first_q <= 1'b0;
      rgb_q     <= 3'b000;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      row_q     <= row_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pv_q      <= pv_d;
      p_blank_q <= p_blank_d;
      p_hs_n_q  <= p_hs_n_d;
      p_vs_n_q  <= p_vs_n_d;
      p_first_q <= p_first_d;
      rgb_q     <= rgb_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign vga_r       = rgb_q[2];
  assign vga_g       = rgb_q[1];
  assign vga_b       = rgb_q[0];
  assign hsync_n     = hs_n_q;
  assign vsync_n     = vs_n_q;
  assign blank_n     = blank_q;
  assign frame_start = fs_q;

endmodule
